// File: rtl/red_pitaya_pwm_bank_if.sv
// System bus port bundle for the PWM bank: the bus master drives the request
// side, the PWM bank answers with read data, acknowledge and error.
interface red_pitaya_pwm_bank_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_pwm_bank.sv
// Multi-channel PWM DAC bank: per-channel source select (DSP sample or bus
// value), slew-limited applied code updated only at period boundaries, and a
// bit-reversed fractional dither that spreads the extra high clocks evenly.
module red_pitaya_pwm_bank #(
  parameter int unsigned CHN  = 4,
  parameter int unsigned DW   = 14,
  parameter int unsigned PW   = 8,
  parameter int unsigned DITW = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [CHN*DW-1:0]   dsp_i,
  output logic [CHN-1:0]      pwm_o,
  output logic                period_o,
  red_pitaya_pwm_bank_if.slave sys
);
  localparam int unsigned AW = PW + DITW;

  logic [CHN-1:0]  src;
  logic            en;
  logic [DW-1:0]   val     [CHN];
  logic [AW-1:0]   step    [CHN];
  logic [AW-1:0]   app     [CHN];
  logic [AW-1:0]   dsp_r   [CHN];
  logic [AW-1:0]   target  [CHN];
  logic [AW-1:0]   app_nxt [CHN];
  logic [AW:0]     diff    [CHN];
  logic [AW:0]     mag     [CHN];
  logic [CHN-1:0]  ext;
  logic [CHN-1:0]  cmp;
  logic [PW-1:0]   cnt;
  logic [DITW-1:0] idx;
  logic [DITW-1:0] idx_rev;
  logic [31:0]     rd_data;
  logic [19:0]     addr;
  logic            base_ok;
  logic [2:0]      grp;
  logic [2:0]      ch;
  logic            unused_ok;

  assign addr    = sys.sys_addr[19:0];
  assign base_ok = (addr[19:8] == '0) && (addr[1:0] == 2'b00);
  assign grp     = addr[7:5];
  assign ch      = addr[4:2];
  assign sys.sys_err = 1'b0;
  assign unused_ok = ^{sys.sys_sel, sys.sys_addr[31:20], sys.sys_wdata, dsp_i};

  // Control, value and step registers written from the bus
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      src <= '0;
      en  <= 1'b0;
      for (int unsigned k = 0; k < CHN; k++) begin
        val[k]  <= '0;
        step[k] <= '0;
      end
    end else if (sys.sys_wen && base_ok) begin
      if (grp == 3'd0 && ch == 3'd0) begin
        src <= sys.sys_wdata[CHN-1:0];
        en  <= sys.sys_wdata[16];
      end
      for (int unsigned k = 0; k < CHN; k++) begin
        if (ch == 3'(k)) begin
          if (grp == 3'd1) val[k]  <= sys.sys_wdata[DW-1:0];
          if (grp == 3'd2) step[k] <= sys.sys_wdata[AW-1:0];
        end
      end
    end
  end

  // Read decode of the register map; unmapped addresses read zero
  always_comb begin
    rd_data = '0;
    if (base_ok) begin
      if (grp == 3'd0 && ch == 3'd0) begin
        rd_data[CHN-1:0] = src;
        rd_data[16]      = en;
      end
      for (int unsigned k = 0; k < CHN; k++) begin
        if (ch == 3'(k)) begin
          case (grp)
            3'd1:    rd_data = 32'(signed'(val[k]));
            3'd2:    rd_data = 32'(step[k]);
            3'd3:    rd_data = 32'(app[k]);
            default: ;
          endcase
        end
      end
    end
  end

  // Bus response: acknowledge one cycle after every request
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sys.sys_ack   <= 1'b0;
      sys.sys_rdata <= '0;
    end else begin
      sys.sys_ack   <= sys.sys_wen | sys.sys_ren;
      sys.sys_rdata <= sys.sys_ren ? rd_data : '0;
    end
  end

  // Register the top code bits of each DSP sample
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < CHN; k++) dsp_r[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < CHN; k++) dsp_r[k] <= dsp_i[k*DW + (DW-AW) +: AW];
    end
  end

  // Target code (offset binary) and slew-limited next applied code
  always_comb begin
    for (int unsigned k = 0; k < CHN; k++) begin
      target[k]       = src[k] ? dsp_r[k] : val[k][DW-1 -: AW];
      target[k][AW-1] = ~target[k][AW-1];
      diff[k]         = {1'b0, target[k]} - {1'b0, app[k]};
      mag[k]          = diff[k][AW] ? (~diff[k] + (AW+1)'(1)) : diff[k];
      if (step[k] == '0 || mag[k] <= {1'b0, step[k]}) app_nxt[k] = target[k];
      else if (diff[k][AW])                             app_nxt[k] = app[k] - step[k];
      else                                              app_nxt[k] = app[k] + step[k];
    end
  end

  // Shared period counter and dither period index, held at zero while disabled
  always_ff @(posedge clk_i) begin
    if (!rstn_i || !en) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + PW'(1);
      if (cnt == '1) idx <= idx + DITW'(1);
    end
  end

  // Applied code changes only on the last clock of a period
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < CHN; k++) app[k] <= '0;
    end else if (en && cnt == '1) begin
      for (int unsigned k = 0; k < CHN; k++) app[k] <= app_nxt[k];
    end
  end

  // Dithered duty compare, one bit wider than the counter so full-high is reachable
  always_comb begin
    for (int unsigned i = 0; i < DITW; i++) idx_rev[i] = idx[DITW-1-i];
    for (int unsigned k = 0; k < CHN; k++) begin
      ext[k] = app[k][DITW-1:0] > idx_rev;
      cmp[k] = {1'b0, cnt} < ({1'b0, app[k][AW-1:DITW]} + (PW+1)'(ext[k]));
    end
  end

  // Registered PWM outputs and period strobe
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pwm_o    <= '0;
      period_o <= 1'b0;
    end else begin
      pwm_o    <= en ? cmp : '0;
      period_o <= en && (cnt == '0);
    end
  end
endmodule

// File: tb/tb_red_pitaya_pwm_bank.sv
// Directed testbench for red_pitaya_pwm_bank: bus register vectors from a
// table, plus hand-written multi-period sequences for PWM width, dither,
// slew, boundary, enable and reset behaviour.
`timescale 1ns/1ps
module tb_red_pitaya_pwm_bank;
  localparam int CHN  = 4;
  localparam int DW   = 14;
  localparam int PW   = 8;
  localparam int DITW = 4;
  localparam int PER  = 256;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [CHN*DW-1:0] dsp;
  logic [CHN-1:0]    pwm;
  logic              period;

  red_pitaya_pwm_bank_if bus();

  red_pitaya_pwm_bank #(.CHN(CHN), .DW(DW), .PW(PW), .DITW(DITW)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .dsp_i    (dsp),
    .pwm_o    (pwm),
    .period_o (period),
    .sys      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int widths [32];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } bus_vec_t;

  bus_vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic ack);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    @(negedge clk);
    bus.sys_wen = 1'b0;
    ack = bus.sys_ack;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic ack;
    bus_wr(a, d, ack);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic ack, output logic err);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    @(negedge clk);
    bus.sys_ren = 1'b0;
    d   = bus.sys_rdata;
    ack = bus.sys_ack;
    err = bus.sys_err;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic ack, err;
    bus_rd(a, d, ack, err);
    chk(name, d, exp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.sys_wen = 1'b0;
    bus.sys_ren = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the first negedge (current one included) where period_o is high
  task automatic wait_period(input string name);
    int n;
    n = 0;
    while (!period && n < 2*PER) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(period), 32'd1);
  endtask

  task automatic measure(input int chn, input int n);
    int c;
    wait_period("measure start");
    for (int p = 0; p < n; p++) begin
      c = 0;
      for (int i = 0; i < PER; i++) begin
        if (pwm[chn]) c++;
        @(negedge clk);
      end
      widths[p] = c;
    end
  endtask

  task automatic restart(input logic [31:0] ctrl);
    wr(32'h00, 32'h0);
    wr(32'h00, ctrl);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        a, e;
    int          tot, c, expw;

    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_sel   = 4'hF;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;
    dsp           = '0;

    tbl[0]  = '{1'b0, 32'h00,  32'h0,        32'h0};
    tbl[1]  = '{1'b0, 32'h60,  32'h0,        32'h0};
    tbl[2]  = '{1'b1, 32'h28,  32'h3FFF,     32'h0};
    tbl[3]  = '{1'b0, 32'h28,  32'h0,        32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, 32'h7C,  32'h0,        32'h0};
    tbl[5]  = '{1'b0, 32'h100, 32'h0,        32'h0};
    tbl[6]  = '{1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0};
    tbl[7]  = '{1'b0, 32'h100, 32'h0,        32'h0};
    tbl[8]  = '{1'b1, 32'h44,  32'hFFFF_FABC, 32'h0};
    tbl[9]  = '{1'b0, 32'h44,  32'h0,        32'h0000_0ABC};
    tbl[10] = '{1'b1, 32'h24,  32'h0000_1234, 32'h0};
    tbl[11] = '{1'b0, 32'h24,  32'h0,        32'h0000_1234};
    tbl[12] = '{1'b1, 32'h00,  32'h0000_000A, 32'h0};
    tbl[13] = '{1'b0, 32'h00,  32'h0,        32'h0000_000A};
    tbl[14] = '{1'b1, 32'h04,  32'hFFFF_FFFF, 32'h0};
    tbl[15] = '{1'b0, 32'h00,  32'h0,        32'h0000_000A};

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset pwm_o", 32'(pwm), 32'h0);
    chk("reset period_o", 32'(period), 32'h0);
    chk("reset sys_ack", 32'(bus.sys_ack), 32'h0);
    chk("reset sys_err", 32'(bus.sys_err), 32'h0);
    chk("reset sys_rdata", bus.sys_rdata, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Bus register vectors
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].we) begin
        bus_wr(tbl[i].addr, tbl[i].data, a);
        chk($sformatf("vec%0d write ack", i), 32'(a), 32'h1);
      end else begin
        bus_rd(tbl[i].addr, d, a, e);
        chk($sformatf("vec%0d rdata", i), d, tbl[i].exp);
        chk($sformatf("vec%0d read ack", i), 32'(a), 32'h1);
        chk($sformatf("vec%0d err", i), 32'(e), 32'h0);
      end
      chk($sformatf("vec%0d ack drop", i), 32'(bus.sys_ack), 32'h0);
    end

    // Negative full scale on all channels from dsp
    do_reset();
    for (int k = 0; k < CHN; k++) dsp[k*DW +: DW] = 14'h2000;
    wr(32'h00, 32'h0001_000F);
    wait_period("negfs start");
    tot = 0;
    for (int i = 0; i < 32*PER; i++) begin
      if (pwm != '0) tot++;
      @(negedge clk);
    end
    chk("negfs high clocks", 32'(tot), 32'h0);
    for (int k = 0; k < CHN; k++) rd_chk($sformatf("negfs applied%0d", k), 32'h60 + 32'(4*k), 32'h0);

    // Mid-scale with fraction 8: alternating 129/128 widths
    do_reset();
    dsp = '0;
    wr(32'h20, 32'h0000_0020);
    wr(32'h00, 32'h0001_0000);
    repeat (2*PER + 4) @(negedge clk);
    rd_chk("mid applied0", 32'h60, 32'h808);
    restart(32'h0001_0000);
    measure(0, 16);
    tot = 0;
    for (int p = 0; p < 16; p++) begin
      expw = (p % 2 == 0) ? 129 : 128;
      chk($sformatf("mid width p%0d", p), 32'(widths[p]), 32'(expw));
      tot += widths[p];
    end
    chk("mid 16-period total", 32'(tot), 32'd2056);

    // Positive full scale on channel 1 from dsp
    do_reset();
    dsp = '0;
    dsp[1*DW +: DW] = 14'h1FFF;
    wr(32'h00, 32'h0001_0002);
    repeat (2*PER + 4) @(negedge clk);
    rd_chk("posfs applied1", 32'h64, 32'hFFF);
    restart(32'h0001_0002);
    measure(1, 16);
    for (int p = 0; p < 16; p++) begin
      expw = (p == 15) ? 255 : 256;
      chk($sformatf("posfs width p%0d", p), 32'(widths[p]), 32'(expw));
    end

    // Slew up to 0x800 and back down to 0 in steps of 0x100
    do_reset();
    dsp = '0;
    wr(32'h40, 32'h100);
    wr(32'h20, 32'h0);
    wr(32'h00, 32'h0001_0000);
    for (int i = 0; i < 10; i++) begin
      wait_period("slew up strobe");
      expw = (i * 256 > 2048) ? 2048 : i * 256;
      rd_chk($sformatf("slew up %0d", i), 32'h60, 32'(expw));
    end
    wr(32'h20, 32'h2000);
    for (int i = 1; i < 10; i++) begin
      wait_period("slew down strobe");
      expw = (i >= 8) ? 0 : 2048 - i * 256;
      rd_chk($sformatf("slew down %0d", i), 32'h60, 32'(expw));
    end

    // VAL write mid-period only affects the next period
    do_reset();
    dsp = '0;
    wr(32'h20, 32'h0);
    wr(32'h00, 32'h0001_0000);
    repeat (2*PER + 4) @(negedge clk);
    wait_period("boundary start");
    c = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm[0]) c++;
      if (i == 50) begin
        bus.sys_addr  = 32'h20;
        bus.sys_wdata = 32'h1000;
        bus.sys_wen   = 1'b1;
      end else begin
        bus.sys_wen = 1'b0;
      end
      @(negedge clk);
    end
    chk("boundary current width", 32'(c), 32'd128);
    c = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm[0]) c++;
      @(negedge clk);
    end
    chk("boundary next width", 32'(c), 32'd192);

    // Clearing enable mid-period
    repeat (10) @(negedge clk);
    chk("pre-disable pwm0", 32'(pwm[0]), 32'h1);
    bus.sys_addr  = 32'h00;
    bus.sys_wdata = 32'h0;
    bus.sys_wen   = 1'b1;
    @(negedge clk);
    bus.sys_wen = 1'b0;
    @(negedge clk);
    chk("disable pwm_o", 32'(pwm), 32'h0);
    chk("disable period_o", 32'(period), 32'h0);
    tot = 0;
    for (int i = 0; i < 2*PER; i++) begin
      if (pwm != '0 || period) tot++;
      @(negedge clk);
    end
    chk("disabled quiet", 32'(tot), 32'h0);
    rd_chk("disabled applied hold", 32'h60, 32'hC00);

    // Re-enable: strobe one cycle after cnt restarts at 0
    bus.sys_addr  = 32'h00;
    bus.sys_wdata = 32'h0001_0000;
    bus.sys_wen   = 1'b1;
    @(negedge clk);
    bus.sys_wen = 1'b0;
    chk("reenable period_o early", 32'(period), 32'h0);
    @(negedge clk);
    chk("reenable period_o", 32'(period), 32'h1);
    chk("reenable pwm0", 32'(pwm[0]), 32'h1);

    // Reset asserted mid-period
    repeat (20) @(negedge clk);
    chk("pre-reset pwm0", 32'(pwm[0]), 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid reset pwm_o", 32'(pwm), 32'h0);
    chk("mid reset period_o", 32'(period), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    rd_chk("post reset applied0", 32'h60, 32'h0);
    rd_chk("post reset ctrl", 32'h00, 32'h0);
    rd_chk("post reset val0", 32'h20, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
